fetch_prefetch_queue: RTL and testbench

//   Decoupling buffer between instruction fetch/InstROM and the fetch-decode pipeline register.

---
 rtl/fetch_prefetch_queue_if.sv | 29 ++
 rtl/fetch_prefetch_queue.sv | 68 ++++++
 tb/tb_fetch_prefetch_queue.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_queue_if.sv
// Bus between the fetch prefetch queue, its InstROM, the redirect source and the FD register.
interface fetch_prefetch_queue_if #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned PC_W    = 8,
   parameter int unsigned INSTR_W = 32
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic               flush;
   logic [PC_W-1:0]    flush_pc;
   logic               stall;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_instr;
   logic               out_valid;
   logic [PC_W-1:0]    out_pc;
   logic [INSTR_W-1:0] out_instr;
   logic [CNT_W-1:0]   count;

   // master is the queue itself; slave is the surrounding pipeline and ROM
   modport master (
      input  flush, flush_pc, stall, imem_instr,
      output imem_addr, out_valid, out_pc, out_instr, count
   );

   modport slave (
      output flush, flush_pc, stall, imem_instr,
      input  imem_addr, out_valid, out_pc, out_instr, count
   );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Prefetch queue between InstROM and decode: owns the fetch PC, buffers up to DEPTH
// {pc, instr} pairs across decode stalls and drops everything on a redirect.
module fetch_prefetch_queue #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned PC_W    = 8,
   parameter int unsigned INSTR_W = 32
) (
   input logic                    clk,
   input logic                    rst,
   fetch_prefetch_queue_if.master bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PC_W-1:0]    fetch_pc;
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [CNT_W-1:0]   occupancy;
   logic [PC_W-1:0]    pc_mem    [DEPTH];
   logic [INSTR_W-1:0] instr_mem [DEPTH];

   logic head_valid;
   logic pop;
   logic push;

   // Redirect turns the head into a bubble in the same cycle
   assign head_valid = (occupancy != '0) && !bus.flush;
   assign pop        = head_valid && !bus.stall;
   assign push       = !bus.flush && ((occupancy < CNT_W'(DEPTH)) || pop);

   assign bus.imem_addr = fetch_pc;
   assign bus.out_valid = head_valid;
   assign bus.out_pc    = head_valid ? pc_mem[head]    : '0;
   assign bus.out_instr = head_valid ? instr_mem[head] : '0;
   assign bus.count     = occupancy;

   // Pointer, occupancy and fetch PC update
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc  <= '0;
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
      end else if (bus.flush) begin
         fetch_pc  <= bus.flush_pc;
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            tail     <= tail + PTR_W'(1);
            fetch_pc <= fetch_pc + PC_W'(1);
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Entry storage carries no reset; occupancy alone qualifies it
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         pc_mem[tail]    <= fetch_pc;
         instr_mem[tail] <= bus.imem_instr;
      end
   end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a ROM model returning A000_0000 + addr.
module tb_fetch_prefetch_queue;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned PC_W    = 8;
   localparam int unsigned INSTR_W = 32;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   fetch_prefetch_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

   fetch_prefetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.imem_instr = 32'hA000_0000 + 32'(bus.imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      rst          = 1'b1;
      bus.flush    = 1'b0;
      bus.flush_pc = '0;
      bus.stall    = 1'b0;

      // T1: reset then free-running fetch
      tick();
      chk("t1_rst_valid", 64'(bus.out_valid), 64'h0);
      chk("t1_rst_count", 64'(bus.count), 64'h0);
      tick();
      chk("t1_rst_valid2", 64'(bus.out_valid), 64'h0);
      chk("t1_rst_pc", 64'(bus.out_pc), 64'h0);
      chk("t1_rst_instr", 64'(bus.out_instr), 64'h0);
      chk("t1_rst_addr", 64'(bus.imem_addr), 64'h0);
      rst = 1'b0;
      tick();
      chk("t1_pc0", 64'(bus.out_pc), 64'h0);
      chk("t1_instr0", 64'(bus.out_instr), 64'hA000_0000);
      chk("t1_valid0", 64'(bus.out_valid), 64'h1);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("t1_pc_seq", 64'(bus.out_pc), 64'(k));
         chk("t1_count_seq", 64'(bus.count), 64'h1);
      end

      // T2: stall fills the queue
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      bus.stall = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("t2_count", 64'(bus.count), 64'((k < 4) ? k : 4));
         chk("t2_addr", 64'(bus.imem_addr), 64'((k < 4) ? k : 4));
         chk("t2_pc_hold", 64'(bus.out_pc), 64'h0);
      end

      // T2/T3: release stall, full queue pushes and pops each cycle
      bus.stall = 1'b0;
      #1;
      chk("t2_rel_pc0", 64'(bus.out_pc), 64'h0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("t3_pc", 64'(bus.out_pc), 64'(k));
         chk("t3_count", 64'(bus.count), 64'h4);
         chk("t3_addr", 64'(bus.imem_addr), 64'(4 + k));
      end

      // T4: flush with stall at count=3
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      bus.stall = 1'b1;
      tick();
      tick();
      tick();
      chk("t4_count3", 64'(bus.count), 64'h3);
      bus.flush    = 1'b1;
      bus.flush_pc = 8'h40;
      #1;
      chk("t4_bubble_valid", 64'(bus.out_valid), 64'h0);
      chk("t4_bubble_instr", 64'(bus.out_instr), 64'h0);
      tick();
      bus.flush = 1'b0;
      bus.stall = 1'b0;
      chk("t4_count0", 64'(bus.count), 64'h0);
      chk("t4_addr", 64'(bus.imem_addr), 64'h40);
      chk("t4_empty_valid", 64'(bus.out_valid), 64'h0);
      tick();
      chk("t4_pc", 64'(bus.out_pc), 64'h40);
      chk("t4_instr", 64'(bus.out_instr), 64'hA000_0040);

      // Back-to-back flush: last target wins
      bus.flush    = 1'b1;
      bus.flush_pc = 8'h20;
      tick();
      bus.flush_pc = 8'h30;
      tick();
      bus.flush = 1'b0;
      chk("b2b_addr", 64'(bus.imem_addr), 64'h30);
      tick();
      chk("b2b_pc", 64'(bus.out_pc), 64'h30);

      // T5: PC wrap
      bus.flush    = 1'b1;
      bus.flush_pc = 8'hFE;
      tick();
      bus.flush = 1'b0;
      tick();
      chk("t5_pc_fe", 64'(bus.out_pc), 64'hFE);
      tick();
      chk("t5_pc_ff", 64'(bus.out_pc), 64'hFF);
      tick();
      chk("t5_pc_00", 64'(bus.out_pc), 64'h00);
      chk("t5_instr_00", 64'(bus.out_instr), 64'hA000_0000);
      tick();
      chk("t5_pc_01", 64'(bus.out_pc), 64'h01);

      // T6: reset mid-run with count=2 and stall
      bus.flush    = 1'b1;
      bus.flush_pc = 8'h10;
      tick();
      bus.flush = 1'b0;
      bus.stall = 1'b1;
      tick();
      tick();
      chk("t6_count2", 64'(bus.count), 64'h2);
      chk("t6_pc_pre", 64'(bus.out_pc), 64'h10);
      rst = 1'b1;
      tick();
      chk("t6_count0", 64'(bus.count), 64'h0);
      chk("t6_addr0", 64'(bus.imem_addr), 64'h0);
      rst       = 1'b0;
      bus.stall = 1'b0;
      tick();
      chk("t6_pc0", 64'(bus.out_pc), 64'h0);
      tick();
      chk("t6_pc1", 64'(bus.out_pc), 64'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
